// File: rtl/ctr_drbg_stream_ctrl.sv
// CTR_DRBG controller (no derivation function) for AES-128/256 key lengths.
// Sequences Instantiate / Reseed / Generate / Uninstantiate, drives an external
// block cipher through a req/ack handshake and streams Generate output one
// 128-bit block at a time through a valid/ready port (no pipelining).
module ctr_drbg_stream_ctrl #(
  parameter int          KEYLEN          = 256,
  parameter int          SEEDLEN         = KEYLEN + 128,
  parameter logic [31:0] RESEED_INTERVAL = 32'h0001_0000,
  parameter int          MAX_BLOCKS      = 16,
  parameter int          CNTW            = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         operation,
  input  logic [SEEDLEN-1:0] entropy_input,
  input  logic [SEEDLEN-1:0] additional_input,
  input  logic [CNTW-1:0]    num_blocks,
  output logic               enc_req,
  output logic [KEYLEN-1:0]  enc_key,
  output logic [127:0]       enc_in,
  input  logic               enc_ack,
  input  logic [127:0]       enc_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_data,
  output logic               out_last,
  output logic [KEYLEN-1:0]  key,
  output logic [127:0]       v,
  output logic [31:0]        reseed_counter,
  output logic               instantiated,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               needs_reseed
);

  // Number of cipher calls per Update and derived constants.
  localparam int              NB        = SEEDLEN / 128;
  localparam logic [1:0]      NB_LAST_C = 2'(NB - 1);
  localparam logic [CNTW-1:0] MAX_BLK_C = CNTW'(MAX_BLOCKS);
  localparam logic [CNTW-1:0] ONE_BLK_C = CNTW'(1);

  // FSM states.
  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_CHECK    = 4'd1;
  localparam logic [3:0] S_UPD_ENC  = 4'd2;
  localparam logic [3:0] S_UPD_WAIT = 4'd3;
  localparam logic [3:0] S_UPD_FIN  = 4'd4;
  localparam logic [3:0] S_GEN_ENC  = 4'd5;
  localparam logic [3:0] S_GEN_WAIT = 4'd6;
  localparam logic [3:0] S_GEN_OUT  = 4'd7;
  localparam logic [3:0] S_FINISH   = 4'd8;

  // Operation encodings.
  localparam logic [1:0] OP_INST   = 2'b00;
  localparam logic [1:0] OP_GEN    = 2'b01;
  localparam logic [1:0] OP_RESEED = 2'b10;
  localparam logic [1:0] OP_UNINST = 2'b11;

  // What to do once an Update finishes.
  localparam logic [1:0] UPD_INST   = 2'd0;
  localparam logic [1:0] UPD_RESEED = 2'd1;
  localparam logic [1:0] UPD_PRE    = 2'd2;
  localparam logic [1:0] UPD_POST   = 2'd3;

  logic [3:0]         state_r;
  logic [1:0]         op_r;
  logic [SEEDLEN-1:0] ent_r;
  logic [SEEDLEN-1:0] add_r;
  logic [CNTW-1:0]    nb_r;
  logic [CNTW-1:0]    blk_idx_r;
  logic [SEEDLEN-1:0] pd_r;
  logic [SEEDLEN-1:0] temp_r;
  logic [1:0]         upd_idx_r;
  logic [1:0]         upd_next_r;
  logic [KEYLEN-1:0]  key_r;
  logic [127:0]       v_r;
  logic [31:0]        rc_r;
  logic               inst_r;
  logic               busy_r;
  logic               done_r;
  logic               err_r;
  logic               enc_req_r;
  logic [127:0]       enc_in_r;
  logic               out_valid_r;
  logic [127:0]       out_data_r;
  logic               out_last_r;

  logic [SEEDLEN-1:0] upd_res_s;
  logic               gen_reject_s;
  logic               last_blk_s;

  // Full-width 128-bit counter increment, wrapping all-ones to zero.
  function automatic logic [127:0] inc128(input logic [127:0] x);
    return x + 128'd1;
  endfunction

  assign upd_res_s    = temp_r ^ pd_r;
  assign gen_reject_s = !inst_r || (nb_r == {CNTW{1'b0}}) || (nb_r > MAX_BLK_C) ||
                        (rc_r > RESEED_INTERVAL);
  assign last_blk_s   = ((blk_idx_r + ONE_BLK_C) == nb_r);

  // Main sequencer: operand capture, Update / Generate sequencing, handshakes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      op_r        <= 2'b00;
      ent_r       <= {SEEDLEN{1'b0}};
      add_r       <= {SEEDLEN{1'b0}};
      nb_r        <= {CNTW{1'b0}};
      blk_idx_r   <= {CNTW{1'b0}};
      pd_r        <= {SEEDLEN{1'b0}};
      temp_r      <= {SEEDLEN{1'b0}};
      upd_idx_r   <= 2'd0;
      upd_next_r  <= UPD_INST;
      key_r       <= {KEYLEN{1'b0}};
      v_r         <= 128'd0;
      rc_r        <= 32'd0;
      inst_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      enc_req_r   <= 1'b0;
      enc_in_r    <= 128'd0;
      out_valid_r <= 1'b0;
      out_data_r  <= 128'd0;
      out_last_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        // Idle (and the done cycle, where busy is already low): accept a request.
        S_IDLE, S_FINISH: begin
          if (start) begin
            op_r    <= operation;
            ent_r   <= entropy_input;
            add_r   <= additional_input;
            nb_r    <= num_blocks;
            busy_r  <= 1'b1;
            state_r <= S_CHECK;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_CHECK: begin
          upd_idx_r <= 2'd0;
          blk_idx_r <= {CNTW{1'b0}};
          case (op_r)
            OP_INST: begin
              key_r      <= {KEYLEN{1'b0}};
              v_r        <= 128'd0;
              pd_r       <= ent_r ^ add_r;
              upd_next_r <= UPD_INST;
              state_r    <= S_UPD_ENC;
            end
            OP_RESEED: begin
              if (!inst_r) begin
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
                err_r   <= 1'b1;
                state_r <= S_FINISH;
              end else begin
                pd_r       <= ent_r ^ add_r;
                upd_next_r <= UPD_RESEED;
                state_r    <= S_UPD_ENC;
              end
            end
            OP_GEN: begin
              if (gen_reject_s) begin
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
                err_r   <= 1'b1;
                state_r <= S_FINISH;
              end else if (add_r != {SEEDLEN{1'b0}}) begin
                pd_r       <= add_r;
                upd_next_r <= UPD_PRE;
                state_r    <= S_UPD_ENC;
              end else begin
                state_r <= S_GEN_ENC;
              end
            end
            OP_UNINST: begin
              key_r   <= {KEYLEN{1'b0}};
              v_r     <= 128'd0;
              rc_r    <= 32'd0;
              inst_r  <= 1'b0;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= S_FINISH;
            end
            default: begin
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              err_r   <= 1'b1;
              state_r <= S_FINISH;
            end
          endcase
        end
        S_UPD_ENC: begin
          v_r       <= inc128(v_r);
          enc_in_r  <= inc128(v_r);
          enc_req_r <= 1'b1;
          state_r   <= S_UPD_WAIT;
        end
        S_UPD_WAIT: begin
          if (enc_ack) begin
            enc_req_r <= 1'b0;
            temp_r    <= {temp_r[SEEDLEN-129:0], enc_out};
            if (upd_idx_r == NB_LAST_C) begin
              state_r <= S_UPD_FIN;
            end else begin
              upd_idx_r <= upd_idx_r + 2'd1;
              state_r   <= S_UPD_ENC;
            end
          end else begin
            state_r <= S_UPD_WAIT;
          end
        end
        S_UPD_FIN: begin
          key_r     <= upd_res_s[SEEDLEN-1 -: KEYLEN];
          v_r       <= upd_res_s[127:0];
          upd_idx_r <= 2'd0;
          case (upd_next_r)
            UPD_INST: begin
              rc_r    <= 32'd1;
              inst_r  <= 1'b1;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= S_FINISH;
            end
            UPD_RESEED: begin
              rc_r    <= 32'd1;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= S_FINISH;
            end
            UPD_PRE: begin
              state_r <= S_GEN_ENC;
            end
            UPD_POST: begin
              rc_r    <= rc_r + 32'd1;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= S_FINISH;
            end
            default: begin
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              err_r   <= 1'b1;
              state_r <= S_FINISH;
            end
          endcase
        end
        S_GEN_ENC: begin
          v_r       <= inc128(v_r);
          enc_in_r  <= inc128(v_r);
          enc_req_r <= 1'b1;
          state_r   <= S_GEN_WAIT;
        end
        S_GEN_WAIT: begin
          if (enc_ack) begin
            enc_req_r   <= 1'b0;
            out_data_r  <= enc_out;
            out_last_r  <= last_blk_s;
            out_valid_r <= 1'b1;
            state_r     <= S_GEN_OUT;
          end else begin
            state_r <= S_GEN_WAIT;
          end
        end
        // Hold the block until the consumer takes it; only then move on.
        S_GEN_OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            if (out_last_r) begin
              pd_r       <= add_r;
              upd_next_r <= UPD_POST;
              upd_idx_r  <= 2'd0;
              state_r    <= S_UPD_ENC;
            end else begin
              blk_idx_r <= blk_idx_r + ONE_BLK_C;
              state_r   <= S_GEN_ENC;
            end
          end else begin
            state_r <= S_GEN_OUT;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign enc_req        = enc_req_r;
  assign enc_key        = key_r;
  assign enc_in         = enc_in_r;
  assign out_valid      = out_valid_r;
  assign out_data       = out_data_r;
  assign out_last       = out_last_r;
  assign key            = key_r;
  assign v              = v_r;
  assign reseed_counter = rc_r;
  assign instantiated   = inst_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign error          = err_r;
  assign needs_reseed   = (rc_r > RESEED_INTERVAL);

endmodule

// File: tb/tb_ctr_drbg_stream_ctrl.sv
// Self-checking bench for ctr_drbg_stream_ctrl (KEYLEN=256, RESEED_INTERVAL=2).
// A stub cipher returns ~plaintext; a behavioural DRBG model predicts every
// cipher request, output block and final state, and a compare process checks
// the DUT against those predictions each cycle.
module tb_ctr_drbg_stream_ctrl;
  localparam int SL = 384;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    operation = 2'b00;
  logic [SL-1:0] entropy_input = '0;
  logic [SL-1:0] additional_input = '0;
  logic [7:0]    num_blocks = 8'd0;
  logic          enc_req;
  logic [255:0]  enc_key;
  logic [127:0]  enc_in;
  logic          enc_ack = 1'b0;
  logic [127:0]  enc_out = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [127:0]  out_data;
  logic          out_last;
  logic [255:0]  key;
  logic [127:0]  v;
  logic [31:0]   reseed_counter;
  logic          instantiated, busy, done, error, needs_reseed;

  always #5 clk = ~clk;

  ctr_drbg_stream_ctrl #(.KEYLEN(256), .RESEED_INTERVAL(32'd2), .MAX_BLOCKS(16), .CNTW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .operation(operation),
    .entropy_input(entropy_input), .additional_input(additional_input),
    .num_blocks(num_blocks), .enc_req(enc_req), .enc_key(enc_key), .enc_in(enc_in),
    .enc_ack(enc_ack), .enc_out(enc_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .key(key), .v(v),
    .reseed_counter(reseed_counter), .instantiated(instantiated), .busy(busy),
    .done(done), .error(error), .needs_reseed(needs_reseed));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic         err;
    logic [255:0] k;
    logic [127:0] v;
    logic [31:0]  rc;
    logic         inst;
  } done_t;

  logic [255:0] m_k = '0;
  logic [127:0] m_v = '0;
  logic [31:0]  m_rc = '0;
  logic         m_inst = 1'b0;
  logic [127:0] q_in[$];
  logic [255:0] q_key[$];
  logic [128:0] q_out[$];
  done_t        q_done[$];
  logic [127:0] log_in[$];
  logic [127:0] log_out[$];

  task automatic m_update(input logic [383:0] pd);
    logic [383:0] t;
    t = '0;
    for (int i = 0; i < 3; i++) begin
      m_v = m_v + 128'd1;
      q_in.push_back(m_v);
      q_key.push_back(m_k);
      t[383 - 128*i -: 128] = ~m_v;
    end
    t = t ^ pd;
    m_k = t[383:128];
    m_v = t[127:0];
  endtask

  task automatic m_op(input logic [1:0] op, input logic [383:0] ent, input logic [383:0] add,
                      input logic [7:0] nb);
    done_t d;
    logic err;
    err = 1'b0;
    case (op)
      2'b00: begin
        m_k = '0; m_v = '0; m_update(ent ^ add); m_rc = 32'd1; m_inst = 1'b1;
      end
      2'b10: begin
        if (!m_inst) err = 1'b1;
        else begin m_update(ent ^ add); m_rc = 32'd1; end
      end
      2'b01: begin
        if (!m_inst || nb == 8'd0 || nb > 8'd16 || m_rc > 32'd2) err = 1'b1;
        else begin
          if (add != '0) m_update(add);
          for (int b = 1; b <= int'(nb); b++) begin
            m_v = m_v + 128'd1;
            q_in.push_back(m_v);
            q_key.push_back(m_k);
            q_out.push_back({(b == int'(nb)), ~m_v});
          end
          m_update(add);
          m_rc = m_rc + 32'd1;
        end
      end
      default: begin
        m_k = '0; m_v = '0; m_rc = '0; m_inst = 1'b0;
      end
    endcase
    d.err = err; d.k = m_k; d.v = m_v; d.rc = m_rc; d.inst = m_inst;
    q_done.push_back(d);
  endtask

  // ---------------- stub cipher: enc_out = ~enc_in ----------------
  bit           pend = 1'b0;
  int           wait_c = 0;
  logic [127:0] lat_in = '0;
  always @(negedge clk) begin
    enc_ack = 1'b0;
    if (pend) begin
      if (wait_c == 1) begin
        enc_ack = 1'b1; enc_out = ~lat_in; pend = 1'b0;
      end else wait_c++;
    end else if (enc_req) begin
      pend = 1'b1; wait_c = 0; lat_in = enc_in;
    end
  end

  // ---------------- consumer ----------------
  int bp_cnt = 0;
  bit rnd_ready = 1'b0;
  always @(negedge clk) begin
    if (bp_cnt > 0 && out_valid) begin
      out_ready = 1'b0; bp_cnt--;
    end else if (rnd_ready) out_ready = (($urandom % 3) != 0);
    else out_ready = 1'b1;
  end

  // ---------------- compare process ----------------
  logic         p_req = 1'b0, p_valid = 1'b0, p_last = 1'b0;
  logic [127:0] p_in = '0, p_data = '0;
  logic [255:0] p_key = '0;
  logic         last_err = 1'b0;
  int           vcyc = 0;
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      p_req = 1'b0; p_valid = 1'b0;
    end else begin
      if (enc_req && !p_req) begin
        if (q_in.size() == 0) chk("unexpected_enc_req", 1'b1, 1'b0);
        else begin
          chk("enc_in", enc_in, q_in.pop_front());
          chk("enc_key", enc_key, q_key.pop_front());
          log_in.push_back(enc_in);
        end
      end else if (p_req && !enc_ack) begin
        chk("enc_req_held", enc_req, 1'b1);
        chk("enc_in_stable", enc_in, p_in);
        chk("enc_key_stable", enc_key, p_key);
      end else if (p_req && enc_ack) begin
        chk("enc_req_drop", enc_req, 1'b0);
      end
      if (out_valid) vcyc++;
      if (p_valid && !out_ready) begin
        chk("out_valid_held", out_valid, 1'b1);
        chk("out_data_stable", out_data, p_data);
        chk("out_last_stable", out_last, p_last);
      end else if (out_valid) begin
        if (q_out.size() == 0) chk("unexpected_out_valid", 1'b1, 1'b0);
        else begin
          chk("out_block", {out_last, out_data}, q_out.pop_front());
          log_out.push_back(out_data);
        end
      end
      if (out_valid && enc_req) chk("req_during_out", 1'b1, 1'b0);
      if (error && !done) chk("error_without_done", 1'b1, 1'b0);
      if (done) begin
        done_t d;
        if (q_done.size() == 0) chk("unexpected_done", 1'b1, 1'b0);
        else begin
          d = q_done.pop_front();
          last_err = error;
          chk("done_error", error, d.err);
          chk("done_key", key, d.k);
          chk("done_v", v, d.v);
          chk("done_rc", reseed_counter, d.rc);
          chk("done_inst", instantiated, d.inst);
          chk("done_needs_reseed", needs_reseed, (d.rc > 32'd2));
          chk("done_busy_low", busy, 1'b0);
          chk("done_queues_drained", q_in.size() + q_out.size(), 0);
        end
      end
      p_req = enc_req; p_in = enc_in; p_key = enc_key;
      p_valid = out_valid; p_data = out_data; p_last = out_last;
    end
  end

  // ---------------- driver ----------------
  function automatic logic [383:0] rnd384();
    logic [383:0] r;
    for (int i = 0; i < 12; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic start_op(input logic [1:0] op, input logic [383:0] ent, input logic [383:0] add,
                          input logic [7:0] nb);
    @(negedge clk);
    operation = op; entropy_input = ent; additional_input = add; num_blocks = nb;
    start = 1'b1;
    m_op(op, ent, add, nb);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    operation = 2'($urandom); entropy_input = rnd384(); additional_input = rnd384();
    num_blocks = 8'($urandom);
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (c < 3000) begin
      @(posedge clk); #3;
      start = 1'b0;
      if (done) break;
      if (busy && ($urandom % 8 == 0)) begin
        start = 1'b1; operation = 2'($urandom);
      end
      c++;
    end
    start = 1'b0;
    if (c >= 3000) chk("done_timeout", 1'b1, 1'b0);
  endtask

  task automatic do_op(input logic [1:0] op, input logic [383:0] ent, input logic [383:0] add,
                       input logic [7:0] nb);
    start_op(op, ent, add, nb);
    wait_done();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_enc_req"}, enc_req, 1'b0);
    chk({tag, "_enc_key"}, enc_key, '0);
    chk({tag, "_enc_in"}, enc_in, '0);
    chk({tag, "_out"}, {out_valid, out_last, out_data}, '0);
    chk({tag, "_key_v"}, {key, v}, '0);
    chk({tag, "_rc"}, reseed_counter, '0);
    chk({tag, "_flags"}, {instantiated, busy, done, error, needs_reseed}, '0);
  endtask

  initial begin
    logic [383:0] zero384;
    int c;
    bit saw_ack;
    zero384 = '0;
    repeat (3) @(posedge clk);
    #3;
    check_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    // Instantiate with all-zero inputs: hand-computed result.
    log_in.delete();
    do_op(2'b00, zero384, zero384, 8'd0);
    chk("inst_log_len", log_in.size(), 3);
    if (log_in.size() == 3) begin
      chk("inst_in0", log_in[0], 128'd1);
      chk("inst_in1", log_in[1], 128'd2);
      chk("inst_in2", log_in[2], 128'd3);
    end
    chk("inst_key_lit", key, {~128'd1, ~128'd2});
    chk("inst_v_lit", v, {{124{1'b1}}, 4'hC});
    chk("inst_rc_lit", reseed_counter, 32'd1);
    chk("inst_err_lit", last_err, 1'b0);

    // Generate two blocks, no additional input.
    log_in.delete(); log_out.delete();
    do_op(2'b01, zero384, zero384, 8'd2);
    chk("gen_out_len", log_out.size(), 2);
    if (log_out.size() == 2) begin
      chk("gen_out0_lit", log_out[0], 128'd2);
      chk("gen_out1_lit", log_out[1], 128'd1);
    end
    chk("gen_in_len", log_in.size(), 5);
    if (log_in.size() == 5) begin
      chk("gen_upd0_lit", log_in[2], {128{1'b1}});
      chk("gen_upd1_lit", log_in[3], 128'd0);
      chk("gen_upd2_lit", log_in[4], 128'd1);
    end
    chk("gen_rc_lit", reseed_counter, 32'd2);

    // Backpressure on the first block.
    vcyc = 0; bp_cnt = 10;
    do_op(2'b01, zero384, rnd384(), 8'd1);
    chk("bp_hold_cycles", (vcyc >= 11), 1'b1);
    chk("bp_rc_lit", reseed_counter, 32'd3);
    chk("bp_needs_reseed_lit", needs_reseed, 1'b1);

    // Over the reseed interval, then reseed.
    do_op(2'b01, zero384, zero384, 8'd1);
    chk("interval_err_lit", last_err, 1'b1);
    do_op(2'b10, rnd384(), rnd384(), 8'd0);
    chk("reseed_rc_lit", reseed_counter, 32'd1);
    chk("reseed_needs_lit", needs_reseed, 1'b0);

    // Error paths.
    do_op(2'b11, zero384, zero384, 8'd0);
    chk("uninst_inst_lit", instantiated, 1'b0);
    do_op(2'b01, zero384, zero384, 8'd1);
    chk("gen_uninst_err_lit", last_err, 1'b1);
    do_op(2'b10, rnd384(), zero384, 8'd0);
    chk("reseed_uninst_err_lit", last_err, 1'b1);
    do_op(2'b00, rnd384(), rnd384(), 8'd0);
    do_op(2'b01, zero384, rnd384(), 8'd0);
    chk("nb0_err_lit", last_err, 1'b1);
    do_op(2'b01, zero384, rnd384(), 8'd17);
    chk("nb17_err_lit", last_err, 1'b1);
    do_op(2'b01, zero384, rnd384(), 8'd16);

    // Randomized operations.
    rnd_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      logic [1:0] op;
      logic [7:0] nb;
      logic [383:0] add;
      c = int'($urandom % 10);
      op = (c < 5) ? 2'b01 : (c < 7) ? 2'b10 : (c < 9) ? 2'b00 : 2'b11;
      nb = ($urandom % 8 == 0) ? (($urandom % 2 == 0) ? 8'd0 : 8'd17) : 8'($urandom_range(1, 4));
      add = ($urandom % 2 == 0) ? zero384 : rnd384();
      do_op(op, rnd384(), add, nb);
    end

    // Reset while a generate block is waiting for its cipher result.
    rnd_ready = 1'b0;
    do_op(2'b00, rnd384(), rnd384(), 8'd0);
    start_op(2'b01, zero384, zero384, 8'd4);
    c = 0;
    while (!enc_req && c < 50) begin
      @(posedge clk); #3; c++;
    end
    if (c >= 50) chk("reset_test_req_timeout", 1'b1, 1'b0);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #3;
    check_all_zero("midrun_reset");
    @(negedge clk); rst_n = 1'b1;
    q_in.delete(); q_key.delete(); q_out.delete(); q_done.delete();
    m_k = '0; m_v = '0; m_rc = '0; m_inst = 1'b0;
    saw_ack = 1'b0;
    repeat (8) begin
      @(posedge clk); #3;
      if (enc_ack) saw_ack = 1'b1;
    end
    chk("late_ack_delivered", saw_ack, 1'b1);
    check_all_zero("after_late_ack");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
